// File: rtl/div_pkg.sv
// Shared widths and FSM state type for the radix (non-restoring) signed divider.
package div_pkg;
    localparam int unsigned DVD_W  = 16;
    localparam int unsigned DVS_W  = 8;
    localparam int unsigned ITER_N = 16;
    localparam int unsigned CNT_W  = $clog2(ITER_N);
    localparam int unsigned PR_W   = DVS_W + 1;
    localparam int unsigned MAG_W  = DVD_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        FIX,
        DONE
    } state_t;
endpackage

// File: rtl/radix_divider_if.sv
// Operand/result bundle between a divider client (master) and the divider (slave).
interface radix_divider_if;
    import div_pkg::*;

    logic [DVD_W-1:0] dvdnd;
    logic [DVS_W-1:0] dvsr;
    logic             go;
    logic [DVS_W-1:0] quot;
    logic [DVS_W-1:0] rem;
    logic             over;
    logic             dz;
    logic             ovf;

    modport master (output dvdnd, dvsr, go, input quot, rem, over, dz, ovf);
    modport slave  (input dvdnd, dvsr, go, output quot, rem, over, dz, ovf);
endinterface

// File: rtl/div_addsub.sv
// 9-bit add/subtract step shared by the iteration and the final remainder fix-up.
module div_addsub
    import div_pkg::*;
(
    input  logic [PR_W-1:0] a,
    input  logic [PR_W-1:0] b,
    input  logic            sub,
    output logic [PR_W-1:0] sum_c
);
    assign sum_c = sub ? (a - b) : (a + b);
endmodule

// File: rtl/radix_divider.sv
// Signed 16/8 non-restoring divider, one quotient bit per cycle.
// Define RADIX_DIVIDER_OVF_CHECK_EN to build the quotient-overflow flag; otherwise ovf is tied low.
module radix_divider
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    radix_divider_if.slave  bus
);
`ifdef RADIX_DIVIDER_OVF_CHECK_EN
    localparam int unsigned QS_W = MAG_W;
`else
    localparam int unsigned QS_W = DVS_W;
`endif

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [DVD_W-1:0] a_lat, a_lat_n;
    logic [DVS_W-1:0] b_lat, b_lat_n;
    logic [PR_W-1:0]  pr, pr_n;
    logic [DVD_W-1:0] q, q_n;
    logic [PR_W-1:0]  d, d_n;
    logic             qneg, qneg_n;
    logic             rneg, rneg_n;
    logic [DVS_W-1:0] quot, quot_n;
    logic [DVS_W-1:0] rem, rem_n;
    logic             over, over_n;
    logic             dz, dz_n;
    logic             ovf, ovf_n;

    // Operand magnitudes; 17-bit dividend extension keeps -32768 exact.
    logic [MAG_W-1:0] a_ext;
    logic [DVD_W-1:0] a_mag;
    logic [PR_W-1:0]  b_ext;
    logic [PR_W-1:0]  b_mag;

    assign a_ext = {a_lat[DVD_W-1], a_lat};
    assign a_mag = DVD_W'(a_lat[DVD_W-1] ? -a_ext : a_ext);
    assign b_ext = {b_lat[DVS_W-1], b_lat};
    assign b_mag = b_lat[DVS_W-1] ? -b_ext : b_ext;

    // Single adder: shifted remainder +/- divisor while iterating, remainder + divisor in FIX.
    logic [PR_W-1:0] pr_sh;
    logic [PR_W-1:0] as_a;
    logic            as_sub;
    logic [PR_W-1:0] as_sum;

    assign pr_sh  = {pr[PR_W-2:0], q[DVD_W-1]};
    assign as_a   = (state == FIX) ? pr : pr_sh;
    assign as_sub = (state == FIX) ? 1'b0 : ~pr[PR_W-1];

    div_addsub u_addsub (
        .a     (as_a),
        .b     (d),
        .sub   (as_sub),
        .sum_c (as_sum)
    );

    logic [DVS_W-1:0] r_mag;
    logic [QS_W-1:0]  q_s;
    logic             ovf_c;

    assign r_mag = DVS_W'(pr[PR_W-1] ? as_sum : pr);
    assign q_s   = qneg ? -QS_W'(q) : QS_W'(q);

`ifdef RADIX_DIVIDER_OVF_CHECK_EN
    // In range only when bits [16:7] are a pure sign extension.
    assign ovf_c = !((&q_s[QS_W-1:DVS_W-1]) || !(|q_s[QS_W-1:DVS_W-1]));
`else
    assign ovf_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_lat <= '0;
            b_lat <= '0;
            pr    <= '0;
            q     <= '0;
            d     <= '0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
            quot  <= '0;
            rem   <= '0;
            over  <= 1'b0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            a_lat <= a_lat_n;
            b_lat <= b_lat_n;
            pr    <= pr_n;
            q     <= q_n;
            d     <= d_n;
            qneg  <= qneg_n;
            rneg  <= rneg_n;
            quot  <= quot_n;
            rem   <= rem_n;
            over  <= over_n;
            dz    <= dz_n;
            ovf   <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_lat_n = a_lat;
        b_lat_n = b_lat;
        pr_n    = pr;
        q_n     = q;
        d_n     = d;
        qneg_n  = qneg;
        rneg_n  = rneg;
        quot_n  = quot;
        rem_n   = rem;
        over_n  = over;
        dz_n    = dz;
        ovf_n   = ovf;

        case (state)
            IDLE: begin
                if (bus.go) begin
                    a_lat_n = bus.dvdnd;
                    b_lat_n = bus.dvsr;
                    over_n  = 1'b0;
                    dz_n    = 1'b0;
                    ovf_n   = 1'b0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                q_n    = a_mag;
                d_n    = b_mag;
                pr_n   = '0;
                qneg_n = a_lat[DVD_W-1] ^ b_lat[DVS_W-1];
                rneg_n = a_lat[DVD_W-1];
                cnt_n  = '0;
                if (b_lat == '0) begin
                    dz_n    = 1'b1;
                    quot_n  = '0;
                    rem_n   = '0;
                    ovf_n   = 1'b0;
                    state_n = DONE;
                end else begin
                    state_n = ITER;
                end
            end
            ITER: begin
                pr_n  = as_sum;
                q_n   = {q[DVD_W-2:0], ~as_sum[PR_W-1]};
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(ITER_N - 1)) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                quot_n  = q_s[DVS_W-1:0];
                rem_n   = rneg ? -r_mag : r_mag;
                ovf_n   = ovf_c;
                state_n = DONE;
            end
            DONE: begin
                // Always present over for at least one cycle, then release once go drops.
                over_n = 1'b1;
                if (!bus.go && over) begin
                    over_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.quot = quot;
    assign bus.rem  = rem;
    assign bus.over = over;
    assign bus.dz   = dz;
    assign bus.ovf  = ovf;
endmodule

// File: tb/tb_radix_divider.sv
// Directed self-checking bench for radix_divider; expected results hand-computed.
module tb_radix_divider;
`ifdef RADIX_DIVIDER_OVF_CHECK_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif
    localparam int LAT_NORM = 1 + 19;
    localparam int LAT_DZ   = 1 + 2;

    logic clk;
    logic reset;
    int   vectors;
    int   errors;

    radix_divider_if bus ();

    radix_divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [15:0] a, input logic [7:0] b,
                       input int lat, input logic [7:0] eq, input logic [7:0] er,
                       input logic edz, input logic eovf);
        int n;
        bus.dvdnd = a;
        bus.dvsr  = b;
        bus.go    = 1'b1;
        tick();
        n = 1;
        // Operands must already be latched; these values must have no effect.
        bus.dvdnd = 16'h7fff;
        bus.dvsr  = 8'h01;
        while (bus.over !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, ".lat"}, n, lat);
        chk({tag, ".quot"}, bus.quot, eq);
        chk({tag, ".rem"}, bus.rem, er);
        chk({tag, ".dz"}, bus.dz, edz);
        chk({tag, ".ovf"}, bus.ovf, eovf);
        repeat (3) tick();
        chk({tag, ".hold"}, {bus.over, bus.quot, bus.rem}, {1'b1, eq, er});
        bus.go = 1'b0;
        tick();
        chk({tag, ".release"}, bus.over, 1'b0);
    endtask

    initial begin
        int n;
        vectors   = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.go    = 1'b0;
        bus.dvdnd = '0;
        bus.dvsr  = '0;
        repeat (2) tick();
        chk("reset_state", {bus.quot, bus.rem, bus.over, bus.dz, bus.ovf}, '0);
        reset = 1'b0;
        tick();

        run("351/27",     16'd351,    8'd27,   LAT_NORM, 8'h0D, 8'h00, 1'b0, 1'b0);
        run("-175/25",    -16'sd175,  8'd25,   LAT_NORM, 8'hF9, 8'h00, 1'b0, 1'b0);
        run("100/-7",     16'd100,    -8'sd7,  LAT_NORM, 8'hF2, 8'h02, 1'b0, 1'b0);
        run("5/0",        16'd5,      8'd0,    LAT_DZ,   8'h00, 8'h00, 1'b1, 1'b0);
        run("1000/7",     16'd1000,   8'd7,    LAT_NORM, 8'h8E, 8'h06, 1'b0, OVF_EN);
        run("-32768/-128",16'h8000,   8'h80,   LAT_NORM, 8'h00, 8'h00, 1'b0, OVF_EN);
        run("-32767/-128",16'h8001,   8'h80,   LAT_NORM, 8'hFF, 8'h81, 1'b0, OVF_EN);
        run("127/-128",   16'd127,    8'h80,   LAT_NORM, 8'h00, 8'h7F, 1'b0, 1'b0);
        run("128/-1",     16'd128,    8'hFF,   LAT_NORM, 8'h80, 8'h00, 1'b0, 1'b0);
        run("128/1",      16'd128,    8'd1,    LAT_NORM, 8'h80, 8'h00, 1'b0, OVF_EN);
        run("-100/7",     -16'sd100,  8'd7,    LAT_NORM, 8'hF2, 8'hFE, 1'b0, 1'b0);

        // Reset mid-division, then restart with go still held.
        bus.dvdnd = 16'd351;
        bus.dvsr  = 8'd27;
        bus.go    = 1'b1;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        chk("midreset.outs", {bus.quot, bus.rem, bus.over, bus.dz, bus.ovf}, '0);
        reset = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.over !== 1'b1 && n < 40);
        chk("midreset.lat", n, LAT_NORM);
        chk("midreset.quot", bus.quot, 8'h0D);
        chk("midreset.rem", bus.rem, 8'h00);
        bus.go = 1'b0;
        tick();
        chk("midreset.release", bus.over, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/radix_divider.md
RADIX_DIVIDER -- requirements
Module: radix_divider

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: dvdnd  input  16  signed two's-complement dividend.
REQ-004 SHALL have port: dvsr  input  8  signed two's-complement divisor.
REQ-005 SHALL have port: go  input  1  level start request.
REQ-006 SHALL have port: quot  output  8  signed quotient, registered.
REQ-007 SHALL have port: rem  output  8  signed remainder, registered.
REQ-008 SHALL have port: over  output  1  result-valid flag, registered.
REQ-009 SHALL have port: dz  output  1  divide-by-zero flag, registered.
REQ-010 SHALL have port: ovf  output  1  quotient-overflow flag, registered.

Function
REQ-011 SHALL compute truncating signed division: dvdnd = quot*dvsr + rem, |rem| < |dvsr|, rem sign = dvdnd sign, or rem = 0.
REQ-012 SHALL use non-restoring division on operand magnitudes, one quotient bit per cycle, 16 iterations, 9-bit partial remainder.
REQ-013 SHALL implement FSM states IDLE, LOAD, ITER, FIX, DONE.
REQ-014 IDLE: on go=1, SHALL latch dvdnd/dvsr, clear over/dz/ovf, enter LOAD.
REQ-015 LOAD: SHALL take magnitudes, record result signs; if latched dvsr = 0, enter DONE, else enter ITER with iteration counter = 0.
REQ-016 ITER: SHALL perform one shift plus add/sub per cycle; after the 16th iteration, enter FIX.
REQ-017 FIX: SHALL apply the final remainder correction (add divisor if negative), apply signs, evaluate overflow, load quot/rem, enter DONE.
REQ-018 over SHALL rise on the 19th rising edge after the edge that sampled go (divide-by-zero: the 2nd).
REQ-019 DONE: SHALL hold over=1 and quot/rem/dz/ovf stable while go=1; on go=0, enter IDLE with over cleared next edge.
REQ-020 SHALL ignore go and input changes outside IDLE; operands used are those latched in IDLE.
REQ-021 Divide-by-zero: SHALL set dz=1, quot=8'h00, rem=8'h00, ovf=0.
REQ-022 Quotient range: SHALL treat a signed result outside [-128,127] as overflow; quot = low 8 bits of the true quotient.
REQ-023 dvdnd = -32768 and dvsr = -128 SHALL be handled via 17-bit magnitude, without sign-extension error.

Reset
REQ-024 reset=1 at any edge, including mid-ITER, SHALL force IDLE and quot=0, rem=0, over=0, dz=0, ovf=0, counter=0.
REQ-025 go held high when reset deasserts SHALL start a new division on the first edge with reset=0.

Configuration
REQ-026 Macro RADIX_DIVIDER_OVF_CHECK_EN defined: SHALL compute and drive ovf per REQ-022.
REQ-027 Macro undefined: ovf SHALL be tied 0, quot still = truncated low 8 bits; no overflow logic synthesized.

Structure
REQ-028 Package div_pkg SHALL hold DVD_W=16, DVS_W=8, ITER_N=16, counter width, and the FSM state typedef.
REQ-029 Sub-module div_addsub SHALL implement the 9-bit add/subtract step (operand a, operand b, sub select -> sum); instantiated once.

Verification
REQ-030 dvdnd=351, dvsr=27, go=1 -> over after 19 cycles, quot=13, rem=0, dz=0, ovf=0.
REQ-031 dvdnd=-175, dvsr=25 -> quot=-7 (8'hF9), rem=0; dvdnd=100, dvsr=-7 -> quot=-14 (8'hF2), rem=2.
REQ-032 dvdnd=-100, dvsr=7 -> quot=-14 (8'hF2), rem=-2 (8'hFE); result held while go=1, over=0 one edge after go=0.
REQ-033 dvdnd=5, dvsr=0 -> over on 2nd edge, dz=1, quot=0, rem=0.
REQ-034 dvdnd=1000, dvsr=7 -> quot=8'h8E, rem=6; ovf=1 with macro, ovf=0 without.
REQ-035 reset pulsed 8 cycles into dvdnd=351, dvsr=27 -> all outputs 0 next edge; fresh go gives quot=13 after 19 further cycles.
